// File: rtl/plane_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : plane_streamer
//  Purpose  : Streams one plane of pixel words from a ROM, where NUM_PLANES
//             planes of DEPTH words each are stored back-to-back. Words go to a
//             downstream FIFO in ascending address order. A small skid buffer
//             absorbs ROM read latency, so back-pressure never drops or
//             duplicates a word.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             start, stop     - begin a frame (IDLE only) / end continuous mode
//             plane_sel       - plane to stream (clamped to NUM_PLANES-1)
//             continuous      - repeat frames until stop
//             full_fifo       - downstream FIFO full
//             rom_rd/rom_addr - ROM read request
//             rom_data        - ROM data, valid ROM_LAT cycles after rom_rd
//             fifo_data/fifo_wr - downstream write port
//             busy, frame_done  - status
//  Revision : 1.0  initial release
// ============================================================================
module plane_streamer #(
    parameter int DATA_W     = 24,
    parameter int DEPTH      = 4800,
    parameter int NUM_PLANES = 4,
    parameter int ADDR_W     = 15,
    parameter int SEL_W      = 2,
    parameter int ROM_LAT    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [SEL_W-1:0]  plane_sel,
    input  logic              continuous,
    input  logic              full_fifo,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] fifo_data,
    output logic              fifo_wr,
    output logic              busy,
    output logic              frame_done
);

    localparam int SKID_DEPTH = ROM_LAT + 2;
    localparam int PTR_W      = $clog2(SKID_DEPTH);
    localparam int CNT_W      = $clog2(SKID_DEPTH + 1);
    localparam int IDX_W      = $clog2(DEPTH + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]  DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_MAX   = PTR_W'(SKID_DEPTH - 1);
    localparam logic [SEL_W-1:0]  PLANE_MAX = SEL_W'(NUM_PLANES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [SEL_W-1:0]   plane_q, plane_d;
    logic               cont_q, cont_d;

    // Bit i set: a read issued i+1 cycles ago whose data is not yet captured.
    logic [ROM_LAT-1:0] vld_q;

    logic [DATA_W-1:0]  skid_mem [SKID_DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   cnt_q;

    logic               skid_empty;
    logic               push;
    logic               room;
    logic               drain_done;
    logic [SEL_W-1:0]   plane_clamped;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    assign plane_clamped = (32'(plane_sel) >= 32'(NUM_PLANES)) ? PLANE_MAX : plane_sel;

    assign skid_empty = (cnt_q == '0);
    assign fifo_wr    = !skid_empty && !full_fifo;
    assign fifo_data  = skid_mem[rd_ptr_q];
    assign push       = vld_q[ROM_LAT-1];

    // Every outstanding read (buffered or still in the ROM pipeline) owns a
    // skid slot, so a new read is allowed only if a slot stays free for it
    // after this cycle's pop. This keeps the buffer from overflowing no
    // matter how full_fifo toggles.
    assign room = (int'(cnt_q) + $countones(vld_q)) < (SKID_DEPTH + int'(fifo_wr));

    assign rom_rd     = (state_q == S_RUN) && (index_q < DEPTH_IDX) && room;
    assign rom_addr   = ADDR_W'(plane_q) * DEPTH_A + ADDR_W'(index_q);
    assign busy       = (state_q != S_IDLE);
    assign drain_done = (state_q == S_DRAIN) && (vld_q == '0) && skid_empty;
    assign frame_done = drain_done;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        plane_d = plane_q;
        cont_d  = cont_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    plane_d = plane_clamped;
                    cont_d  = continuous && !stop;
                    index_d = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (stop) begin
                    cont_d = 1'b0;
                end
                if (rom_rd) begin
                    index_d = index_q + 1'b1;
                    if (index_q == LAST_IDX) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (stop) begin
                    cont_d = 1'b0;
                end
                if (drain_done) begin
                    // A stop arriving on the completion cycle still wins.
                    if (cont_q && !stop) begin
                        plane_d = plane_clamped;
                        index_d = '0;
                        state_d = S_RUN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            plane_q  <= '0;
            cont_q   <= 1'b0;
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            plane_q <= plane_d;
            cont_q  <= cont_d;
            vld_q[0] <= rom_rd;
            for (int i = 1; i < ROM_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (fifo_wr) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !fifo_wr) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!push && fifo_wr) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    // Storage needs no reset: the count and pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            skid_mem[wr_ptr_q] <= rom_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_plane_streamer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plane_streamer
//  Purpose  : Self-checking bench for plane_streamer. Two instances (ROM
//             latency 1 and 3, DEPTH 8, 3 planes) share the control inputs;
//             each has its own ROM model. Observed streams are compared
//             against expected word lists built from plane/index arithmetic.
//  Revision : 1.0  initial release
// ============================================================================
module tb_plane_streamer;

    localparam int DW = 24;
    localparam int AW = 5;
    localparam int NW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          start = 1'b0, stop = 1'b0, continuous = 1'b0, full_fifo = 1'b0;
    logic [1:0]    plane_sel = 2'd0;

    logic          rd1, wr1, busy1, fd1, rd3, wr3, busy3, fd3;
    logic [AW-1:0] addr1, addr3;
    logic [DW-1:0] rdata1, rdata3, fdata1, fdata3;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 24'h5A0000 + {19'd0, a} * 24'h010101;
    endfunction

    // ROM models: data for a read at cycle t is presented during t+LAT.
    logic [AW-1:0] ap1;
    logic [AW-1:0] ap3 [3];
    always @(posedge clk) begin
        ap1    <= addr1;
        ap3[0] <= addr3;
        ap3[1] <= ap3[0];
        ap3[2] <= ap3[1];
    end
    assign rdata1 = rom_word(ap1);
    assign rdata3 = rom_word(ap3[2]);

    plane_streamer #(.DATA_W(DW), .DEPTH(NW), .NUM_PLANES(3), .ADDR_W(AW),
                     .SEL_W(2), .ROM_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .plane_sel(plane_sel),
        .continuous(continuous), .full_fifo(full_fifo), .rom_rd(rd1),
        .rom_addr(addr1), .rom_data(rdata1), .fifo_data(fdata1), .fifo_wr(wr1),
        .busy(busy1), .frame_done(fd1));

    plane_streamer #(.DATA_W(DW), .DEPTH(NW), .NUM_PLANES(3), .ADDR_W(AW),
                     .SEL_W(2), .ROM_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .plane_sel(plane_sel),
        .continuous(continuous), .full_fifo(full_fifo), .rom_rd(rd3),
        .rom_addr(addr3), .rom_data(rdata3), .fifo_data(fdata3), .fifo_wr(wr3),
        .busy(busy3), .frame_done(fd3));

    logic          rd_v [2], wr_v [2], busy_v [2], fd_v [2];
    logic [AW-1:0] addr_v [2];
    logic [DW-1:0] data_v [2];
    assign rd_v[0] = rd1;    assign rd_v[1] = rd3;
    assign wr_v[0] = wr1;    assign wr_v[1] = wr3;
    assign busy_v[0] = busy1; assign busy_v[1] = busy3;
    assign fd_v[0] = fd1;    assign fd_v[1] = fd3;
    assign addr_v[0] = addr1; assign addr_v[1] = addr3;
    assign data_v[0] = fdata1; assign data_v[1] = fdata3;

    // ---------------- monitor ----------------
    logic          clr_req = 1'b0;
    logic [DW-1:0] obs_mem [2][64];
    logic [AW-1:0] adr_mem [2][64];
    int obs_n [2], adr_n [2], frames [2], first_wr [2], last_wr [2];
    int outst [2], max_out [2];
    int cyc = 0;
    int lim [2] = '{3, 5};

    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            if (clr_req) begin
                obs_n[k] = 0; adr_n[k] = 0; frames[k] = 0;
                first_wr[k] = -1; last_wr[k] = -1; max_out[k] = 0;
            end
            if (rst) begin
                outst[k] = 0;
            end else begin
                if (rd_v[k] === 1'b1) begin
                    if (adr_n[k] < 64) adr_mem[k][adr_n[k]] = addr_v[k];
                    adr_n[k]++;
                    outst[k]++;
                end
                if (wr_v[k] === 1'b1) begin
                    if (obs_n[k] < 64) obs_mem[k][obs_n[k]] = data_v[k];
                    obs_n[k]++;
                    outst[k]--;
                    if (first_wr[k] < 0) first_wr[k] = cyc;
                    last_wr[k] = cyc;
                end
                if (fd_v[k] === 1'b1) frames[k]++;
                if (outst[k] > max_out[k]) max_out[k] = outst[k];
            end
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0, failures = 0;
    int bp_cur = 0;
    logic [DW-1:0] exp_w [64];
    logic [AW-1:0] exp_a [64];
    int exp_n = 0;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected frame: words base..base+NW-1 in ascending order.
    task automatic add_frame(input int base);
        for (int i = 0; i < NW; i++) begin
            exp_a[exp_n] = AW'(base + i);
            exp_w[exp_n] = rom_word(AW'(base + i));
            exp_n++;
        end
    endtask

    task automatic chk_reset(input string tag);
        for (int k = 0; k < 2; k++) begin
            check({rd_v[k], wr_v[k], fd_v[k], busy_v[k]} === 4'b0000 && addr_v[k] === '0,
                  $sformatf("%s[%0d] outputs", tag, k),
                  int'({rd_v[k], wr_v[k], fd_v[k], busy_v[k]}) * 64 + int'(addr_v[k]), 0);
        end
    endtask

    task automatic begin_frame(input logic [1:0] p, input bit c, input bit s);
        tick();
        clr_req = 1'b1; plane_sel = p; continuous = c; stop = s; start = 1'b1;
        full_fifo = 1'b0;
        tick();
        clr_req = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
    endtask

    // what: 0 both obs>=n, 1 both frames>=n, 2 dut1 obs>=n, 3 dut1 reads>=n
    task automatic wait_for(input int what, input int n, input string tag);
        int  t = 0;
        bit  done = 1'b0;
        while (!done && t < 3000) begin
            case (what)
                0:       done = obs_n[0] >= n && obs_n[1] >= n;
                1:       done = frames[0] >= n && frames[1] >= n;
                2:       done = obs_n[0] >= n;
                default: done = adr_n[0] >= n;
            endcase
            if (!done) begin
                tick();
                full_fifo = (bp_cur > 0) && (int'($urandom_range(0, 99)) < bp_cur);
                t++;
            end
        end
        full_fifo = 1'b0;
        check(done, {tag, " wait"}, t, 3000);
    endtask

    task automatic wait_frames(input int nf, input string tag);
        wait_for(1, nf, tag);
        repeat (3) tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check(busy_v[k] === 1'b0, $sformatf("%s[%0d] busy_end", tag, k), int'(busy_v[k]), 0);
            check(frames[k] == nf, $sformatf("%s[%0d] frame_done", tag, k), frames[k], nf);
            check(max_out[k] <= lim[k], $sformatf("%s[%0d] skid_occ", tag, k), max_out[k], lim[k]);
        end
    endtask

    task automatic check_all(input string tag, input bit burst);
        for (int k = 0; k < 2; k++) begin
            int bad_d = -1, bad_a = -1, act_d = 0, req_d = 0, act_a = 0, req_a = 0;
            for (int i = 0; i < exp_n && i < 64; i++) begin
                if (bad_d < 0 && i < obs_n[k] && obs_mem[k][i] !== exp_w[i]) begin
                    bad_d = i; act_d = int'(obs_mem[k][i]); req_d = int'(exp_w[i]);
                end
                if (bad_a < 0 && i < adr_n[k] && adr_mem[k][i] !== exp_a[i]) begin
                    bad_a = i; act_a = int'(adr_mem[k][i]); req_a = int'(exp_a[i]);
                end
            end
            check(obs_n[k] == exp_n, $sformatf("%s[%0d] word_count", tag, k), obs_n[k], exp_n);
            check(bad_d < 0, $sformatf("%s[%0d] data@%0d", tag, k, bad_d), act_d, req_d);
            check(adr_n[k] == exp_n, $sformatf("%s[%0d] read_count", tag, k), adr_n[k], exp_n);
            check(bad_a < 0, $sformatf("%s[%0d] addr@%0d", tag, k, bad_a), act_a, req_a);
            if (burst) begin
                check(last_wr[k] - first_wr[k] == exp_n - 1,
                      $sformatf("%s[%0d] burst_span", tag, k),
                      last_wr[k] - first_wr[k], exp_n - 1);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] psel;
        bit         cont;
        bit         stop_too;
        int         bp;
        int         base;    // expected first address
        int         nframes; // expected frame_done pulses
        bit         burst;   // expect back-to-back writes
    } vec_t;

    vec_t vecs [7];

    initial begin
        vecs[0] = '{2'd0, 1'b0, 1'b0,  0,  0, 1, 1'b1};  // basic frame
        vecs[1] = '{2'd2, 1'b0, 1'b0,  0, 16, 1, 1'b1};  // plane select
        vecs[2] = '{2'd3, 1'b0, 1'b0,  0, 16, 1, 1'b1};  // out-of-range clamps
        vecs[3] = '{2'd1, 1'b0, 1'b0, 50,  8, 1, 1'b0};  // back-pressure 50%
        vecs[4] = '{2'd0, 1'b0, 1'b0, 50,  0, 1, 1'b0};
        vecs[5] = '{2'd2, 1'b0, 1'b0, 90, 16, 1, 1'b0};  // heavy back-pressure
        vecs[6] = '{2'd1, 1'b1, 1'b1,  0,  8, 1, 1'b1};  // start+stop: single frame

        repeat (3) tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset("reset");

        for (int v = 0; v < 7; v++) begin
            exp_n = 0;
            add_frame(vecs[v].base);
            bp_cur = vecs[v].bp;
            begin_frame(vecs[v].psel, vecs[v].cont, vecs[v].stop_too);
            wait_frames(vecs[v].nframes, $sformatf("vec%0d", v));
            check_all($sformatf("vec%0d", v), vecs[v].burst);
        end

        // Random planes and back-pressure levels.
        for (int r = 0; r < 4; r++) begin
            int p;
            p = int'($urandom_range(0, 3));
            exp_n = 0;
            add_frame(((p > 2) ? 2 : p) * NW);
            bp_cur = int'($urandom_range(0, 70));
            begin_frame(2'(p), 1'b0, 1'b0);
            wait_frames(1, $sformatf("rnd%0d", r));
            check_all($sformatf("rnd%0d", r), 1'b0);
        end

        // Continuous: plane change in frame 1 takes effect in frame 2; stop in frame 2.
        bp_cur = 0;
        exp_n = 0;
        add_frame(0);
        add_frame(16);
        begin_frame(2'd0, 1'b1, 1'b0);
        wait_for(0, 2, "cont_f1");
        plane_sel = 2'd2;
        wait_for(1, 1, "cont_f2");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_frames(2, "cont");
        check_all("cont", 1'b0);

        // Reset mid-frame, then a fresh frame from word 0.
        exp_n = 0;
        add_frame(8);
        begin_frame(2'd0, 1'b0, 1'b0);
        wait_for(2, 3, "rst_mid");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_reset("rst_mid");
        begin_frame(2'd1, 1'b0, 1'b0);
        wait_frames(1, "after_rst");
        check_all("after_rst", 1'b1);

        // Start while busy is ignored.
        exp_n = 0;
        add_frame(0);
        begin_frame(2'd0, 1'b0, 1'b0);
        wait_for(3, 3, "ign_start");
        start = 1'b1;
        plane_sel = 2'd2;
        tick();
        start = 1'b0;
        wait_frames(1, "ign_start");
        check_all("ign_start", 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
